// File: rtl/gray_frame_ctrl.sv
// gray_frame_ctrl: sequences RGB pixel fetch, converter feed and gray write-back.
// Ports: clk_i/rst_i, Avalon-MM slave (avs_*), Avalon-MM master (avm_*), conv_*, irq_o.
//
// Slave map: 0 CTRL/STATUS {ERROR,DONE,BUSY}, 1 SRC_BASE, 2 DST_BASE, 3 PIX_COUNT[15:0].
// Pixel i component c is read from SRC_BASE+3i+c; its gray byte goes to DST_BASE+i.
module gray_frame_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int COMP_W  = 10,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        avs_address_i,
    input  logic              avs_write_i,
    input  logic              avs_read_i,
    input  logic [31:0]       avs_writedata_i,
    output logic [31:0]       avs_readdata_o,
    output logic [ADDR_W-1:0] avm_address_o,
    output logic              avm_read_o,
    output logic              avm_write_o,
    input  logic              avm_waitrequest_i,
    input  logic [7:0]        avm_readdata_i,
    input  logic              avm_readdatavalid_i,
    output logic [7:0]        avm_writedata_o,
    output logic              conv_start_o,
    output logic [COMP_W-1:0] conv_rgb_o,
    input  logic              conv_valid_i,
    input  logic [7:0]        conv_gray_i,
    output logic              irq_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_START,
        S_GAP,
        S_FEED_R,
        S_FEED_G,
        S_FEED_B,
        S_CONV_WAIT,
        S_WR,
        S_FIN
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [31:0]       src_q;
    logic [31:0]       dst_q;
    logic [15:0]       cnt_q;
    logic [15:0]       pix_q;
    logic [1:0]        idx_q;
    logic [COMP_W-1:0] comp_r_q;
    logic [COMP_W-1:0] comp_g_q;
    logic [COMP_W-1:0] comp_b_q;
    logic [7:0]        gray_q;
    logic [TW-1:0]     tmo_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic [31:0]       rdata_d;

    logic              ctrl_wr;
    logic              cfg_wr;
    logic              go;
    logic [15:0]       pix_nxt;
    logic              last_pix;
    logic              tmo_hit;
    logic              rd_cap;
    logic              wr_done;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;

    // GO is only honoured from idle; config writes are frozen during a run.
    assign ctrl_wr  = avs_write_i && (avs_address_i == 2'd0);
    assign go       = ctrl_wr && avs_writedata_i[0] && !busy_q;
    assign cfg_wr   = avs_write_i && (avs_address_i != 2'd0) && !busy_q;

    assign pix_nxt  = pix_q + 16'd1;
    assign last_pix = (pix_nxt == cnt_q);
    assign tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));
    assign rd_cap   = (state_q == S_RD_WAIT) && avm_readdatavalid_i;
    assign wr_done  = (state_q == S_WR) && !avm_waitrequest_i;

    // 3*i built as 2i + i to avoid a multiplier.
    assign rd_addr  = ADDR_W'(src_q)
                    + ADDR_W'({pix_q, 1'b0})
                    + ADDR_W'(pix_q)
                    + ADDR_W'(idx_q);
    assign wr_addr  = ADDR_W'(dst_q) + ADDR_W'(pix_q);

    assign avs_readdata_o = rdata_q;
    assign irq_o          = done_q | err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bus strobes and converter drive are pure state decodes, so a reset
    // silences them on the very next cycle.
    always_comb begin
        state_d         = state_q;
        avm_read_o      = 1'b0;
        avm_write_o     = 1'b0;
        avm_address_o   = '0;
        avm_writedata_o = '0;
        conv_start_o    = 1'b0;
        conv_rgb_o      = '0;
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = (cnt_q == 16'd0) ? S_FIN : S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                avm_read_o    = 1'b1;
                avm_address_o = rd_addr;
                if (!avm_waitrequest_i) begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (avm_readdatavalid_i) begin
                    state_d = (idx_q == 2'd2) ? S_START : S_RD_REQ;
                end
            end
            S_START: begin
                conv_start_o = 1'b1;
                state_d      = S_GAP;
            end
            S_GAP: begin
                state_d = S_FEED_R;
            end
            S_FEED_R: begin
                conv_rgb_o = comp_r_q;
                state_d    = S_FEED_G;
            end
            S_FEED_G: begin
                conv_rgb_o = comp_g_q;
                state_d    = S_FEED_B;
            end
            S_FEED_B: begin
                conv_rgb_o = comp_b_q;
                state_d    = S_CONV_WAIT;
            end
            S_CONV_WAIT: begin
                if (conv_valid_i) begin
                    state_d = S_WR;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_WR: begin
                avm_write_o     = 1'b1;
                avm_address_o   = wr_addr;
                avm_writedata_o = gray_q;
                if (!avm_waitrequest_i) begin
                    state_d = last_pix ? S_FIN : S_RD_REQ;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rdata_d = '0;
        unique case (avs_address_i)
            2'd0:    rdata_d = {29'd0, err_q, done_q, busy_q};
            2'd1:    rdata_d = src_q;
            2'd2:    rdata_d = dst_q;
            default: rdata_d = {16'd0, cnt_q};
        endcase
    end

    // Later assignments win: status set events take priority over a
    // simultaneous host clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src_q    <= '0;
            dst_q    <= '0;
            cnt_q    <= '0;
            pix_q    <= '0;
            idx_q    <= '0;
            comp_r_q <= '0;
            comp_g_q <= '0;
            comp_b_q <= '0;
            gray_q   <= '0;
            tmo_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (cfg_wr) begin
                unique case (avs_address_i)
                    2'd1:    src_q <= avs_writedata_i;
                    2'd2:    dst_q <= avs_writedata_i;
                    default: cnt_q <= avs_writedata_i[15:0];
                endcase
            end
            if (ctrl_wr && avs_writedata_i[1]) begin
                done_q <= 1'b0;
            end
            if (ctrl_wr && avs_writedata_i[2]) begin
                err_q <= 1'b0;
            end
            if (go) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
                busy_q <= 1'b1;
                pix_q  <= '0;
                idx_q  <= '0;
            end
            if (rd_cap) begin
                unique case (idx_q)
                    2'd0:    comp_r_q <= COMP_W'(avm_readdata_i);
                    2'd1:    comp_g_q <= COMP_W'(avm_readdata_i);
                    default: comp_b_q <= COMP_W'(avm_readdata_i);
                endcase
                idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
            end
            if (state_q == S_FEED_B) begin
                tmo_q <= '0;
            end
            if (state_q == S_CONV_WAIT) begin
                if (conv_valid_i) begin
                    gray_q <= conv_gray_i;
                end else if (tmo_hit) begin
                    err_q  <= 1'b1;
                    busy_q <= 1'b0;
                end else begin
                    tmo_q <= tmo_q + TW'(1);
                end
            end
            if (wr_done) begin
                pix_q <= pix_nxt;
            end
            if (state_q == S_FIN) begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
            end
            if (avs_read_i) begin
                rdata_q <= rdata_d;
            end
        end
    end

endmodule

// File: tb/tb_gray_frame_ctrl.sv
// tb_gray_frame_ctrl: scoreboard bench for gray_frame_ctrl.
// Bus and converter models check traffic against queued expectations.
module tb_gray_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [1:0]  avs_address_i;
    logic        avs_write_i;
    logic        avs_read_i;
    logic [31:0] avs_writedata_i;
    logic [31:0] avs_readdata_o;
    logic [31:0] avm_address_o;
    logic        avm_read_o;
    logic        avm_write_o;
    logic        avm_waitrequest_i;
    logic [7:0]  avm_readdata_i;
    logic        avm_readdatavalid_i;
    logic [7:0]  avm_writedata_o;
    logic        conv_start_o;
    logic [9:0]  conv_rgb_o;
    logic        conv_valid_i;
    logic [7:0]  conv_gray_i;
    logic        irq_o;

    always #5 clk = ~clk;

    gray_frame_ctrl dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .avs_address_i       (avs_address_i),
        .avs_write_i         (avs_write_i),
        .avs_read_i          (avs_read_i),
        .avs_writedata_i     (avs_writedata_i),
        .avs_readdata_o      (avs_readdata_o),
        .avm_address_o       (avm_address_o),
        .avm_read_o          (avm_read_o),
        .avm_write_o         (avm_write_o),
        .avm_waitrequest_i   (avm_waitrequest_i),
        .avm_readdata_i      (avm_readdata_i),
        .avm_readdatavalid_i (avm_readdatavalid_i),
        .avm_writedata_o     (avm_writedata_o),
        .conv_start_o        (conv_start_o),
        .conv_rgb_o          (conv_rgb_o),
        .conv_valid_i        (conv_valid_i),
        .conv_gray_i         (conv_gray_i),
        .irq_o               (irq_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0]  mem [int];
    logic [31:0] q_rd [$];
    logic [39:0] q_wr [$];
    logic [29:0] q_cv [$];
    logic [33:0] q_avs [$];

    logic [23:0] pix_tab  [0:2];
    logic [7:0]  gray_tab [0:2];

    bit stall_mode = 1'b0;
    bit conv_en    = 1'b1;
    int n_start    = 0;

    function automatic void chk(input string nm, input logic [63:0] got,
                                input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endfunction

    function automatic logic [7:0] gray_of(input logic [9:0] r,
                                           input logic [9:0] g,
                                           input logic [9:0] b);
        logic [11:0] s;
        s = 12'(r) + 12'({g, 1'b0}) + 12'(b);
        return s[9:2];
    endfunction

    // Avalon memory model: random stalls, 1..4 cycle read latency.
    initial begin : bus_model
        int          rd_cnt;
        logic [7:0]  rd_data;
        bit          wreq;
        bit          held;
        logic [33:0] held_v;
        logic [31:0] ea;
        logic [39:0] ew;
        rd_cnt              = 0;
        rd_data             = '0;
        held                = 1'b0;
        held_v              = '0;
        avm_waitrequest_i   = 1'b0;
        avm_readdatavalid_i = 1'b0;
        avm_readdata_i      = '0;
        forever begin
            @(negedge clk);
            avm_readdatavalid_i = 1'b0;
            avm_readdata_i      = '0;
            if (rst_i) begin
                rd_cnt            = 0;
                held              = 1'b0;
                avm_waitrequest_i = 1'b0;
                q_rd.delete();
                q_wr.delete();
            end else begin
                if (rd_cnt > 0) begin
                    rd_cnt--;
                    if (rd_cnt == 0) begin
                        avm_readdatavalid_i = 1'b1;
                        avm_readdata_i      = rd_data;
                    end
                end
                if (held) begin
                    chk("stall_hold",
                        {avm_read_o, avm_write_o, avm_address_o}, held_v);
                end
                wreq = 1'b0;
                if (stall_mode && (avm_read_o || avm_write_o)) begin
                    wreq = ($urandom_range(0, 1) == 1);
                end
                avm_waitrequest_i = wreq;
                held   = wreq;
                held_v = {avm_read_o, avm_write_o, avm_address_o};
                if (avm_read_o && !wreq) begin
                    chk("rd_expected", q_rd.size() != 0, 1);
                    chk("rd_one_outstanding", rd_cnt, 0);
                    if (q_rd.size() != 0) begin
                        ea = q_rd.pop_front();
                        chk("rd_addr", avm_address_o, ea);
                    end
                    rd_data = mem[int'(avm_address_o)];
                    rd_cnt  = stall_mode ? int'($urandom_range(1, 4)) : 1;
                end
                if (avm_write_o && !wreq) begin
                    chk("wr_expected", q_wr.size() != 0, 1);
                    if (q_wr.size() != 0) begin
                        ew = q_wr.pop_front();
                        chk("wr_addr_data",
                            {avm_address_o, avm_writedata_o}, ew);
                    end
                end
            end
        end
    end

    // Converter model: checks start/R/G/B spacing, answers 2 cycles after B.
    initial begin : conv_model
        bit          cact;
        int          ck;
        logic [29:0] cexp;
        logic [9:0]  cr;
        logic [9:0]  cg;
        logic [9:0]  cb;
        cact         = 1'b0;
        ck           = 0;
        cexp         = '0;
        cr           = '0;
        cg           = '0;
        cb           = '0;
        conv_valid_i = 1'b0;
        conv_gray_i  = '0;
        forever begin
            @(negedge clk);
            conv_valid_i = 1'b0;
            conv_gray_i  = '0;
            if (rst_i) begin
                cact = 1'b0;
                q_cv.delete();
            end else if (cact) begin
                ck++;
                case (ck)
                    1: chk("conv_gap", {conv_start_o, conv_rgb_o}, 0);
                    2: begin
                        chk("conv_r", conv_rgb_o, cexp[29:20]);
                        cr = conv_rgb_o;
                    end
                    3: begin
                        chk("conv_g", conv_rgb_o, cexp[19:10]);
                        cg = conv_rgb_o;
                    end
                    4: begin
                        chk("conv_b", conv_rgb_o, cexp[9:0]);
                        cb = conv_rgb_o;
                    end
                    5: chk("conv_after_b", conv_rgb_o, 0);
                    default: begin
                        if (conv_en) begin
                            conv_valid_i = 1'b1;
                            conv_gray_i  = gray_of(cr, cg, cb);
                        end
                        cact = 1'b0;
                    end
                endcase
            end else if (conv_start_o) begin
                n_start++;
                chk("conv_start_expected", q_cv.size() != 0, 1);
                if (q_cv.size() != 0) begin
                    cexp = q_cv.pop_front();
                end
                chk("conv_rgb_at_start", conv_rgb_o, 0);
                cact = 1'b1;
                ck   = 0;
            end
        end
    end

    // Slave read monitor: data is due the cycle after the read strobe.
    logic avs_rd_seen = 1'b0;
    always @(posedge clk) avs_rd_seen <= avs_read_i;

    initial begin : avs_mon
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (avs_rd_seen) begin
                chk("avs_rd_expected", q_avs.size() != 0, 1);
                if (q_avs.size() != 0) begin
                    e = q_avs.pop_front();
                    chk($sformatf("avs_rd[%0d]", e[33:32]),
                        avs_readdata_o, e[31:0]);
                end
            end
        end
    end

    task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
        avs_address_i   = a;
        avs_writedata_i = d;
        avs_write_i     = 1'b1;
        @(negedge clk);
        avs_write_i     = 1'b0;
        avs_writedata_i = '0;
    endtask

    task automatic avs_rd(input logic [1:0] a, input logic [31:0] e);
        q_avs.push_back({a, e});
        avs_address_i = a;
        avs_read_i    = 1'b1;
        @(negedge clk);
        avs_read_i    = 1'b0;
        @(negedge clk);
    endtask

    task automatic job(input logic [31:0] src, input logic [31:0] dst,
                       input int n, input bit wr_exp);
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < 3; c++) begin
                mem[int'(src) + 3 * p + c] = pix_tab[p][23 - 8 * c -: 8];
                q_rd.push_back(src + 32'(3 * p + c));
            end
            q_cv.push_back({2'b0, pix_tab[p][23:16], 2'b0, pix_tab[p][15:8],
                            2'b0, pix_tab[p][7:0]});
            if (wr_exp) begin
                q_wr.push_back({dst + 32'(p), gray_tab[p]});
            end
        end
        avs_wr(2'd1, src);
        avs_wr(2'd2, dst);
        avs_wr(2'd3, 32'(n));
        avs_wr(2'd0, 32'd1);
        chk("go_first_read", avm_read_o, n != 0);
    endtask

    task automatic wait_irq(input int budget, input string nm);
        int k = 0;
        while (!irq_o && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_irq"}, irq_o, 1);
    endtask

    task automatic wait_start(input int budget);
        int k = 0;
        while (!conv_start_o && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("start_seen", conv_start_o, 1);
    endtask

    task automatic drained(input string nm);
        chk({nm, "_rd_left"}, q_rd.size(), 0);
        chk({nm, "_wr_left"}, q_wr.size(), 0);
        chk({nm, "_cv_left"}, q_cv.size(), 0);
    endtask

    task automatic load_three();
        pix_tab[0]  = 24'h102030;
        pix_tab[1]  = 24'h804000;
        pix_tab[2]  = 24'hFFFF01;
        gray_tab[0] = 8'h20;
        gray_tab[1] = 8'h40;
        gray_tab[2] = 8'hBF;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i           = 1'b1;
        avs_address_i   = '0;
        avs_write_i     = 1'b0;
        avs_read_i      = 1'b0;
        avs_writedata_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_outputs",
            {avm_read_o, avm_write_o, avm_address_o, avm_writedata_o,
             conv_start_o, conv_rgb_o, irq_o}, 0);
        chk("rst_readdata", avs_readdata_o, 0);
        rst_i = 1'b0;
        @(negedge clk);
        avs_rd(2'd0, 32'd0);
        avs_rd(2'd1, 32'd0);

        // single pixel
        pix_tab[0]  = 24'hEEEEEE;
        gray_tab[0] = 8'hEE;
        n_start     = 0;
        job(32'h100, 32'h200, 1, 1'b1);
        wait_irq(200, "single");
        avs_rd(2'd0, 32'd2);
        chk("single_starts", n_start, 1);
        drained("single");
        avs_wr(2'd0, 32'd2);
        chk("done_clear_irq", irq_o, 0);

        // three pixels plus GO and config writes while busy
        load_three();
        n_start = 0;
        job(32'h100, 32'h200, 3, 1'b1);
        avs_rd(2'd0, 32'd1);
        repeat (3) @(negedge clk);
        avs_wr(2'd0, 32'd1);
        avs_wr(2'd1, 32'h999);
        avs_wr(2'd3, 32'd7);
        wait_irq(400, "three");
        chk("three_starts", n_start, 3);
        drained("three");
        avs_rd(2'd1, 32'h100);
        avs_rd(2'd3, 32'd3);
        avs_rd(2'd0, 32'd2);
        avs_wr(2'd0, 32'd2);

        // random stalls and read latency
        stall_mode = 1'b1;
        n_start    = 0;
        job(32'h100, 32'h200, 3, 1'b1);
        wait_irq(2000, "stall");
        stall_mode = 1'b0;
        @(negedge clk);
        chk("stall_starts", n_start, 3);
        drained("stall");
        avs_wr(2'd0, 32'd2);

        // converter timeout: 64 cycles of CONV_WAIT then ERROR
        conv_en     = 1'b0;
        pix_tab[0]  = 24'h123456;
        job(32'h300, 32'h400, 1, 1'b0);
        wait_start(100);
        repeat (68) @(negedge clk);
        chk("tmo_irq_early", irq_o, 0);
        @(negedge clk);
        chk("tmo_irq", irq_o, 1);
        avs_rd(2'd0, 32'd4);
        drained("tmo");
        avs_wr(2'd0, 32'd4);
        chk("err_clear_irq", irq_o, 0);
        conv_en = 1'b1;

        // zero pixel count: DONE two cycles after GO, no bus traffic
        job(32'h100, 32'h200, 0, 1'b1);
        chk("cnt0_irq_k1", irq_o, 0);
        @(negedge clk);
        chk("cnt0_irq_k2", irq_o, 1);
        repeat (4) @(negedge clk);
        avs_rd(2'd0, 32'd2);
        avs_wr(2'd0, 32'd2);

        // reset in FEED_G, then a clean rerun
        load_three();
        job(32'h100, 32'h200, 2, 1'b1);
        wait_start(100);
        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        chk("midrst_outputs",
            {avm_read_o, avm_write_o, avm_address_o, avm_writedata_o,
             conv_start_o, conv_rgb_o, irq_o}, 0);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        avs_rd(2'd0, 32'd0);
        n_start = 0;
        job(32'h100, 32'h200, 3, 1'b1);
        wait_irq(400, "rerun");
        chk("rerun_starts", n_start, 3);
        drained("rerun");
        avs_rd(2'd0, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
